scan_chain_ctrl: RTL and testbench
==================================

# scan_chain_ctrl

Sequencer for a WIDTH-bit chain of edge-triggered flops used as a scan/configuration register. It captures a parallel word into the chain, shifts it out serially while shifting new data in, then commits the chain into a shadow update register. The block sits between a test or configuration master (start/hold/serial stream) and the logic that consumes the committed parallel word.

## Interface
Parameters:
- WIDTH, 8, chain and update register width (≥2)
- CNT_W, $clog2(WIDTH+1), shift counter width

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sequence; honoured only in IDLE
- capture_en  input  1  sampled with start: 1 = CAPTURE before SHIFT, 0 = skip CAPTURE
- hold  input  1  stalls shifting while in SHIFT
- par_in  input  WIDTH  word loaded into chain during CAPTURE
- scan_in  input  1  serial data entering chain MSB
- scan_out  output  1  chain[0], serial data leaving chain
- chain_q  output  WIDTH  current chain contents
- par_out  output  WIDTH  update (shadow) register
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in DONE

## Operation
- States: IDLE, CAPTURE, SHIFT, UPDATE, DONE; state register, chain, par_out, shift counter, captured mode bit.
- IDLE: start=1 -> CAPTURE if capture_en=1, else SHIFT; shift counter cleared. start=0 -> stay.
- CAPTURE (1 cycle): chain <= par_in; -> SHIFT.
- SHIFT: if hold=0: chain <= {scan_in, chain[WIDTH-1:1]}, counter+1; when counter reaches WIDTH-1 on a non-held edge -> UPDATE. hold=1: chain and counter frozen, state unchanged, no time limit.
- UPDATE (1 cycle): par_out <= chain; -> DONE.
- DONE (1 cycle): done=1; -> IDLE unconditionally.
- start is ignored in every state except IDLE (including DONE); no queuing.
- hold outside SHIFT has no effect.
- par_out changes only in UPDATE or reset; chain changes only in CAPTURE, non-held SHIFT, or reset.
- scan_out, chain_q, busy, done are decoded directly from registers (no combinational path from inputs).
- Counter never exceeds WIDTH-1; exactly WIDTH shifts per sequence.

## Timing
- Reset (async assert, any state): state=IDLE, chain=0, par_out=0, counter=0, scan_out=0, busy=0, done=0. Reset mid-sequence aborts immediately; par_out is not updated.
- Cycle n = period following posedge n; start sampled at edge 0.
- With capture: CAPTURE cycle 1, SHIFT cycles 2..WIDTH+1, UPDATE WIDTH+2, DONE WIDTH+3, IDLE WIDTH+4. busy high cycles 1..WIDTH+3.
- Without capture: SHIFT cycles 1..WIDTH, UPDATE WIDTH+1, DONE WIDTH+2.
- Each cycle of hold=1 sampled in SHIFT adds exactly one cycle to all later milestones.
- scan_out during SHIFT cycle k presents the bit shifted out at the next non-held edge; first bit = par_in[0] when captured.
- par_out valid (new value) from DONE cycle onward, stable until next UPDATE.
- Minimum start-to-start spacing: WIDTH+4 cycles with capture.

## Test plan
- Reset: assert rst mid-SHIFT (WIDTH=8) -> same cycle all outputs 0, state IDLE, par_out keeps 0 even if previously loaded value pending.
- Capture + shift, scan_in=0, par_in=8'hA5 -> scan_out over SHIFT cycles 2..9 = 1,0,1,0,0,1,0,1; par_out=8'h00 at cycle 11; done high only in cycle 11.
- Loopback scan_in=scan_out, par_in=8'h3C, capture_en=1 -> par_out=8'h3C at DONE cycle 11; busy high cycles 1..11.
- Shift-only, capture_en=0, chain initially 0, scan_in=1 -> par_out=8'hFF; done in cycle 10.
- Hold: par_in=8'hA5, loopback, hold=1 for 3 cycles during SHIFT cycle 4 -> chain frozen those cycles, done moves to cycle 14, par_out=8'hA5.
- start pulsed in SHIFT and in DONE -> ignored; no second sequence, busy drops after DONE, done pulses once.

Source files
------------

// File: rtl/scan_chain_ctrl_if.sv
// Handshake and data bundle between a scan/config master and scan_chain_ctrl.
// The master drives the sequence controls and serial input; the slave returns chain state.
interface scan_chain_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             capture_en;
    logic             hold;
    logic [WIDTH-1:0] par_in;
    logic             scan_in;
    logic             scan_out;
    logic [WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] par_out;
    logic             busy;
    logic             done;

    modport master (
        output start, capture_en, hold, par_in, scan_in,
        input  scan_out, chain_q, par_out, busy, done
    );

    modport slave (
        input  start, capture_en, hold, par_in, scan_in,
        output scan_out, chain_q, par_out, busy, done
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: optional parallel capture, WIDTH serial shifts (stallable by hold),
// then commit of the chain into a shadow update register.
module scan_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            rst,
    scan_chain_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    logic             shift_now;

    assign shift_now = (state == SHIFT) && !bus.hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = bus.capture_en ? CAPTURE : SHIFT;
                end
            end
            CAPTURE: state_next = SHIFT;
            SHIFT: begin
                if (shift_now && (cnt == LAST)) begin
                    state_next = UPDATE;
                end
            end
            UPDATE:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain  <= '0;
            shadow <= '0;
            cnt    <= '0;
            mode   <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                cnt  <= '0;
                mode <= bus.capture_en;
            end
            if ((state == CAPTURE) && mode) begin
                chain <= bus.par_in;
            end
            // Counter wraps to zero on the final shift so it never reaches WIDTH.
            if (shift_now) begin
                chain <= {bus.scan_in, chain[WIDTH-1:1]};
                cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (state == UPDATE) begin
                shadow <= chain;
            end
        end
    end

    assign bus.scan_out = chain[0];
    assign bus.chain_q  = chain;
    assign bus.par_out  = shadow;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed self-checking bench for scan_chain_ctrl with WIDTH=8.
// Cycle numbering: the period after the edge that samples start is cycle 1.
module tb_scan_chain_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    logic loop;

    scan_chain_ctrl_if #(.WIDTH(8)) ifc ();

    scan_chain_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (loop) ifc.scan_in = ifc.scan_out;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic launch(input logic cap, input logic [7:0] word);
        @(negedge clk);
        ifc.capture_en = cap;
        ifc.par_in     = word;
        ifc.start      = 1'b1;
        cyc = 0;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.scan_out !== 1'b0 ||
            ifc.chain_q !== 8'h00 || ifc.par_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_init: busy=%b done=%b so=%b chain=%h par=%h, want all 0",
                     ifc.busy, ifc.done, ifc.scan_out, ifc.chain_q, ifc.par_out);
        end
        loop = 1'b0;
        ifc.scan_in = 1'b1;
        launch(1'b1, 8'hF0);
        while (cyc < 5) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.scan_out !== 1'b0 ||
            ifc.chain_q !== 8'h00 || ifc.par_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_shift: busy=%b done=%b so=%b chain=%h par=%h, want all 0",
                     ifc.busy, ifc.done, ifc.scan_out, ifc.chain_q, ifc.par_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (ifc.busy !== 1'b0 || ifc.par_out !== 8'h00 || ifc.done !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort: busy=%b done=%b par=%h, want 0 0 00",
                         ifc.busy, ifc.done, ifc.par_out);
            end
        end
    endtask

    task automatic test_loopback();
        do_reset();
        loop = 1'b1;
        launch(1'b1, 8'h3C);
        while (cyc < 13) begin
            checks++;
            if (ifc.busy !== (cyc >= 1 && cyc <= 11)) begin
                errors++;
                $display("FAIL loop_busy c%0d: got %b want %b", cyc, ifc.busy, (cyc >= 1 && cyc <= 11));
            end
            if (cyc == 11) begin
                checks++;
                if (ifc.par_out !== 8'h3C) begin
                    errors++;
                    $display("FAIL loop_par_out: got %h want 3c", ifc.par_out);
                end
            end
            tick();
        end
        loop = 1'b0;
    endtask

    task automatic test_capture_shift();
        logic [7:0] exp_bits;
        exp_bits = 8'hA5;
        ifc.scan_in = 1'b0;
        launch(1'b1, 8'hA5);
        while (cyc < 13) begin
            if (cyc >= 2 && cyc <= 9) begin
                checks++;
                if (ifc.scan_out !== exp_bits[cyc-2]) begin
                    errors++;
                    $display("FAIL cap_scan_out c%0d: got %b want %b", cyc, ifc.scan_out, exp_bits[cyc-2]);
                end
            end
            checks++;
            if (ifc.done !== (cyc == 11)) begin
                errors++;
                $display("FAIL cap_done c%0d: got %b want %b", cyc, ifc.done, (cyc == 11));
            end
            if (cyc == 10 || cyc == 11) begin
                checks++;
                if (ifc.par_out !== ((cyc == 10) ? 8'h3C : 8'h00)) begin
                    errors++;
                    $display("FAIL cap_par_out c%0d: got %h want %h", cyc, ifc.par_out,
                             (cyc == 10) ? 8'h3C : 8'h00);
                end
            end
            tick();
        end
    endtask

    task automatic test_shift_only();
        do_reset();
        ifc.scan_in = 1'b1;
        launch(1'b0, 8'h00);
        while (cyc < 12) begin
            checks++;
            if (ifc.done !== (cyc == 10)) begin
                errors++;
                $display("FAIL shift_done c%0d: got %b want %b", cyc, ifc.done, (cyc == 10));
            end
            if (cyc == 10) begin
                checks++;
                if (ifc.par_out !== 8'hFF) begin
                    errors++;
                    $display("FAIL shift_par_out: got %h want ff", ifc.par_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_hold();
        loop = 1'b1;
        launch(1'b1, 8'hA5);
        while (cyc < 16) begin
            if (cyc == 4) ifc.hold = 1'b1;
            if (cyc == 7) ifc.hold = 1'b0;
            if (cyc >= 4 && cyc <= 7) begin
                checks++;
                if (ifc.chain_q !== 8'h69) begin
                    errors++;
                    $display("FAIL hold_chain c%0d: got %h want 69", cyc, ifc.chain_q);
                end
            end
            checks++;
            if (ifc.done !== (cyc == 14)) begin
                errors++;
                $display("FAIL hold_done c%0d: got %b want %b", cyc, ifc.done, (cyc == 14));
            end
            if (cyc == 14) begin
                checks++;
                if (ifc.par_out !== 8'hA5) begin
                    errors++;
                    $display("FAIL hold_par_out: got %h want a5", ifc.par_out);
                end
            end
            tick();
        end
        loop = 1'b0;
        ifc.hold = 1'b0;
    endtask

    task automatic test_start_ignored();
        int pulses;
        pulses = 0;
        ifc.scan_in = 1'b0;
        launch(1'b1, 8'h81);
        while (cyc < 18) begin
            ifc.start = (cyc == 5 || cyc == 11);
            if (ifc.done) pulses++;
            checks++;
            if (ifc.busy !== (cyc >= 1 && cyc <= 11)) begin
                errors++;
                $display("FAIL ign_busy c%0d: got %b want %b", cyc, ifc.busy, (cyc >= 1 && cyc <= 11));
            end
            tick();
        end
        ifc.start = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ign_done_count: got %0d want 1", pulses);
        end
        checks++;
        if (ifc.par_out !== 8'h00) begin
            errors++;
            $display("FAIL ign_par_out: got %h want 00", ifc.par_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        loop   = 1'b0;
        rst    = 1'b1;
        ifc.start      = 1'b0;
        ifc.capture_en = 1'b0;
        ifc.hold       = 1'b0;
        ifc.par_in     = '0;
        ifc.scan_in    = 1'b0;
        #1;
        test_reset();
        test_loopback();
        test_capture_shift();
        test_shift_only();
        test_hold();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
